// File: rtl/crumb_pkg.sv
// Shared types and defaults for the crumb collector: FSM state encoding and
// the default word width / stall threshold.
package crumb_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StShift = 2'd1,
    StStall = 2'd2
  } crumb_state_e;

  localparam int unsigned DefWidth   = 8;
  localparam int unsigned DefTimeout = 16;

endpackage

// File: rtl/crumb_watchdog.sv
// Rising-edge detector on the sampled crumb clock plus a stall watchdog that
// counts quiet, enabled cycles while the collector is shifting.
module crumb_watchdog
  import crumb_pkg::*;
#(
  parameter int unsigned TIMEOUT = DefTimeout
) (
  input  logic clk,
  input  logic rst_n,
  input  logic crumb_clk,
  input  logic crumb_en,
  input  logic i_armed,
  output logic rise,
  output logic timeout
);

  logic       r_prev;
  logic [7:0] r_wd;
  logic       w_inc;

  assign rise    = crumb_clk & ~r_prev;
  assign w_inc   = i_armed & crumb_en & ~rise;
  // Fires on the cycle whose increment would make the count reach TIMEOUT.
  assign timeout = w_inc && (r_wd == 8'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_prev <= 1'b0;
      r_wd   <= 8'd0;
    end else begin
      r_prev <= crumb_clk;
      if (w_inc && !timeout) begin
        r_wd <= r_wd + 8'd1;
      end else begin
        r_wd <= 8'd0;
      end
    end
  end

endmodule

// File: rtl/crumb_collector.sv
// Assembles WIDTH-bit words from the last crumb stage's random bits, with a
// valid/ready output register and sticky overrun / phase / stall flags.
module crumb_collector
  import crumb_pkg::*;
#(
  parameter int unsigned WIDTH   = DefWidth,
  parameter int unsigned TIMEOUT = DefTimeout
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             crumb_clk,
  input  logic             crumb_rst_n,
  input  logic             crumb_en,
  input  logic             crumb_rbit,
  input  logic             clr_err,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             overrun,
  output logic             phase_err,
  output logic             stall_err
);

  localparam int unsigned CntW = $clog2(WIDTH);

  crumb_state_e     r_state;
  logic [WIDTH-1:0] r_shreg;
  logic [CntW-1:0]  r_cnt;
  logic [WIDTH-1:0] r_out_data;
  logic             r_out_valid;
  logic             r_overrun;
  logic             r_phase_err;
  logic             r_stall_err;

  logic             w_rise;
  logic             w_timeout;
  logic             w_accept;
  logic             w_complete;
  logic             w_load;
  logic             w_drop;
  logic             w_phase;
  logic             w_hs;
  logic [WIDTH-1:0] w_word;

  crumb_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk       (clk),
    .rst_n     (rst_n),
    .crumb_clk (crumb_clk),
    .crumb_en  (crumb_en),
    .i_armed   (r_state == StShift),
    .rise      (w_rise),
    .timeout   (w_timeout)
  );

  assign w_accept   = w_rise && crumb_en && (r_state != StStall);
  assign w_word     = {r_shreg[WIDTH-2:0], crumb_rbit};
  // The bit count is always 0 in IDLE, so the first bit can never complete.
  assign w_complete = w_accept && (r_cnt == CntW'(WIDTH - 1));
  assign w_hs       = r_out_valid && out_ready;
  assign w_load     = w_complete && (!r_out_valid || out_ready);
  assign w_drop     = w_complete && r_out_valid && !out_ready;
  assign w_phase    = (r_state != StStall) && (crumb_rst_n != crumb_clk);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= StIdle;
      r_shreg     <= '0;
      r_cnt       <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_overrun   <= 1'b0;
      r_phase_err <= 1'b0;
      r_stall_err <= 1'b0;
    end else begin
      case (r_state)
        StIdle:  if (w_accept) r_state <= StShift;
        StShift: if (w_timeout) r_state <= StStall;
        StStall: if (clr_err) r_state <= StIdle;
        default: r_state <= StIdle;
      endcase

      if (w_timeout) begin
        r_shreg <= '0;
        r_cnt   <= '0;
      end else if (w_accept) begin
        r_shreg <= w_word;
        r_cnt   <= w_complete ? '0 : r_cnt + 1'b1;
      end

      if (w_load) begin
        r_out_data  <= w_word;
        r_out_valid <= 1'b1;
      end else if (w_hs) begin
        r_out_valid <= 1'b0;
      end

      // Clear first; a new error in the same cycle overrides the clear.
      if (clr_err) begin
        r_overrun   <= 1'b0;
        r_phase_err <= 1'b0;
        r_stall_err <= 1'b0;
      end
      if (w_drop)    r_overrun   <= 1'b1;
      if (w_phase)   r_phase_err <= 1'b1;
      if (w_timeout) r_stall_err <= 1'b1;
    end
  end

  assign out_data  = r_out_data;
  assign out_valid = r_out_valid;
  assign overrun   = r_overrun;
  assign phase_err = r_phase_err;
  assign stall_err = r_stall_err;

endmodule

// File: doc/crumb_collector.md
CRUMB_COLLECTOR -- requirements
Module: crumb_collector

Interface
REQ-001 Parameter WIDTH SHALL default to 8 and set the assembled word width in bits, legal range 2..32.
REQ-002 Parameter TIMEOUT SHALL default to 16 and set the stall threshold in clk cycles, legal range 4..255.
REQ-003 clk  input  1  system clock; all logic on its rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 crumb_clk  input  1  toggling clock-like output of the last crumb stage, sampled as data on clk.
REQ-006 crumb_rst_n  input  1  toggling reset output of the last crumb stage, in phase with crumb_clk.
REQ-007 crumb_en  input  1  registered enable from the last crumb stage.
REQ-008 crumb_rbit  input  1  random bit from the last crumb stage.
REQ-009 clr_err  input  1  one-cycle pulse that clears sticky error flags and leaves STALL.
REQ-010 out_data  output  WIDTH  assembled word.
REQ-011 out_valid  output  1  out_data holds an unconsumed word.
REQ-012 out_ready  input  1  consumer accepts out_data when out_valid=1 and out_ready=1.
REQ-013 overrun  output  1  sticky flag: a completed word was dropped.
REQ-014 phase_err  output  1  sticky flag: crumb_rst_n differed from crumb_clk.
REQ-015 stall_err  output  1  sticky flag: no crumb_clk rising edge within TIMEOUT cycles while crumb_en=1.

Function
REQ-016 crumb_clk SHALL be registered once (prev); a rising edge is crumb_clk=1 with prev=0 in the same cycle.
REQ-017 The FSM SHALL have three states: IDLE, SHIFT and STALL.
REQ-018 IDLE->SHIFT on the first rising edge with crumb_en=1; that edge's bit SHALL be shifted in.
REQ-019 In SHIFT, each rising edge with crumb_en=1 SHALL shift: shreg <= {shreg[WIDTH-2:0], crumb_rbit}, bit count +1.
REQ-020 Rising edges with crumb_en=0 SHALL be ignored; the partial word and bit count SHALL be kept.
REQ-021 On the WIDTH-th bit, the completed word SHALL load out_data and set out_valid at the same clk edge, i.e. visible one cycle after the edge cycle; the bit count SHALL wrap to 0.
REQ-022 out_valid SHALL clear on a handshake (out_valid=1 and out_ready=1) unless a new word completes in that cycle; in that case the new word SHALL load and out_valid SHALL stay 1 with no overrun.
REQ-023 A word completing while out_valid=1 and out_ready=0 SHALL be dropped, set overrun, and leave out_data unchanged.
REQ-024 A watchdog counter SHALL clear on every rising edge or when crumb_en=0, and otherwise increment while crumb_en=1 in SHIFT.
REQ-025 A watchdog count reaching TIMEOUT SHALL set stall_err, move to STALL and discard the partial word.
REQ-026 STALL SHALL ignore all crumb inputs; clr_err SHALL move STALL->IDLE.
REQ-027 In any state except STALL, crumb_rst_n != crumb_clk SHALL set phase_err without otherwise affecting collection.
REQ-028 clr_err SHALL clear overrun, phase_err and stall_err; a new error in the same cycle SHALL take priority, so the flag stays set.
REQ-029 The output handshake SHALL stay operational in every state, including STALL.

Reset
REQ-030 While rst_n=0 at a clk edge, the FSM SHALL go to IDLE and shreg, bit count, watchdog and prev SHALL clear to 0.
REQ-031 Reset SHALL clear out_data, out_valid, overrun, phase_err and stall_err to 0.
REQ-032 Reset mid-word or mid-handshake SHALL discard all pending data with no output pulse.

Structure
REQ-033 Package crumb_pkg SHALL hold the FSM state enum and the WIDTH/TIMEOUT default constants.
REQ-034 Edge detect and watchdog SHALL be one sub-module, crumb_watchdog, with outputs rise and timeout.

Verification
REQ-035 Drive a crumb-like source with en=1; bits 1,0,1,1,0,0,1,0 on 8 edges, out_ready=1 -> out_data=8'hB2 with a one-cycle out_valid pulse one cycle after the 8th edge.
REQ-036 Hold out_ready=0 over two full words -> first word retained, overrun=1 after the second word completes; clr_err -> overrun=0.
REQ-037 Drop crumb_en after 3 bits for 10 cycles, then resume for 5 bits -> one word, no stall_err.
REQ-038 Hold crumb_clk static with crumb_en=1 in SHIFT -> stall_err=1 exactly TIMEOUT cycles after the last edge; later edges are ignored until clr_err.
REQ-039 Force crumb_rst_n=0 while crumb_clk=1 for one cycle -> phase_err=1 and the word still completes correctly.
REQ-040 Assert rst_n=0 after 5 bits -> all outputs 0; the next 8 bits form a fresh, correct word.
